upe_negate_seq: RTL and testbench

Multi-cycle two's-complement negate/absolute-value sequencer for the UPE arithmetic datapath. It accepts a WIDTH-bit operand over a valid/ready handshake and computes the result LANE bits per cycle through a single lane adder (invert-plus-carry), with the carry registered between lanes. It lets wide negations share a narrow adder lane instead of instantiating a full-width negate unit. It sits between the operand-issue logic and the UPE result path.

---
 rtl/upe_negate_seq_if.sv | 23 ++
 rtl/upe_negate_seq.sv | 111 +++++++++++
 tb/tb_upe_negate_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/upe_negate_seq_if.sv
// rtl/upe_negate_seq_if.sv - operand/result handshake bundle for upe_negate_seq
interface upe_negate_seq_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_op, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_op, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/upe_negate_seq.sv
// rtl/upe_negate_seq.sv - lane-serial negate/abs sequencer; UPE_NEGSEQ_OVF_EN adds the ovf output
module upe_negate_seq #(
  parameter int WIDTH = 64,
  parameter int LANE  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef UPE_NEGSEQ_OVF_EN
  upe_negate_seq_if.slave    bus,
  output logic               ovf
`else
  upe_negate_seq_if.slave    bus
`endif
);
  localparam int N  = WIDTH / LANE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_out_data;
  logic             r_inv;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_busy;

  logic [LANE-1:0]       w_lane;
  logic [LANE:0]         w_sum;
  logic [WIDTH+LANE-1:0] w_cat;
  logic [WIDTH-1:0]      w_res_next;
  logic                  w_inv;

  assign w_inv      = ~bus.in_op | bus.in_data[WIDTH-1];
  assign w_lane     = r_opnd[LANE-1:0];
  assign w_sum      = {1'b0, (r_inv ? ~w_lane : w_lane)} + {{LANE{1'b0}}, r_carry};
  // Each new lane enters at the MSB end, so after N lanes lane 0 sits at the bottom.
  assign w_cat      = {w_sum[LANE-1:0], r_res} >> LANE;
  assign w_res_next = w_cat[WIDTH-1:0];

`ifdef UPE_NEGSEQ_OVF_EN
  logic r_ovf_pend;
  logic r_ovf;
  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_opnd      <= '0;
      r_res       <= '0;
      r_out_data  <= '0;
      r_inv       <= 1'b0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef UPE_NEGSEQ_OVF_EN
      r_ovf_pend  <= 1'b0;
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_opnd  <= bus.in_data;
            r_inv   <= w_inv;
            r_carry <= w_inv;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef UPE_NEGSEQ_OVF_EN
            r_ovf      <= 1'b0;
            r_ovf_pend <= w_inv && (bus.in_data == {1'b1, {(WIDTH-1){1'b0}}});
`endif
          end
        end
        S_RUN: begin
          r_opnd  <= r_opnd >> LANE;
          r_res   <= w_res_next;
          r_carry <= w_sum[LANE];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_out_data  <= w_res_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef UPE_NEGSEQ_OVF_EN
            r_ovf       <= r_ovf_pend;
`endif
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_upe_negate_seq.sv
// tb/tb_upe_negate_seq.sv - self-checking bench for upe_negate_seq (vectors, random vs model, corner sequences)
module tb_upe_negate_seq;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  upe_negate_seq_if #(.WIDTH(64)) bus ();

`ifdef UPE_NEGSEQ_OVF_EN
  logic ovf;
  upe_negate_seq #(.WIDTH(64), .LANE(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .ovf(ovf));
`else
  upe_negate_seq #(.WIDTH(64), .LANE(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        op;
    logic [63:0] din;
    logic [63:0] exp;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_res(input logic op, input logic [63:0] x);
    if (op && !x[63]) return x;
    return 64'd0 - x;
  endfunction

  function automatic logic model_ovf(input logic op, input logic [63:0] x);
    return (!op || x[63]) && (x == MIN64);
  endfunction

  function automatic logic get_ovf();
`ifdef UPE_NEGSEQ_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic run_op(input logic op, input logic [63:0] x,
                        output logic [63:0] res, output int lat, output logic ov);
    @(negedge clk);
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = x;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = 1'($urandom);
    bus.in_data  = {$urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    res = bus.out_data;
    ov  = get_ovf();
    chk("busy_done", {63'd0, bus.busy}, 64'd1);
    @(posedge clk);
    #1;
    chk("out_valid_one_cycle", {63'd0, bus.out_valid}, 64'd0);
    chk("busy_after", {63'd0, bus.busy}, 64'd0);
  endtask

  task automatic check_op(input string name, input logic op, input logic [63:0] x,
                          input logic [63:0] exp, input logic exp_ovf);
    logic [63:0] res;
    int          lat;
    logic        ov;
    run_op(op, x, res, lat, ov);
    chk({name, "_data"}, res, exp);
    chk({name, "_latency"}, 64'(lat), 64'd4);
`ifdef UPE_NEGSEQ_OVF_EN
    chk({name, "_ovf"}, {63'd0, ov}, {63'd0, exp_ovf});
`else
    if (ov !== 1'b0 && exp_ovf === 1'bx) chk({name, "_ovf"}, {63'd0, ov}, 64'd0);
`endif
  endtask

  initial begin
    vec_t vt[8];
    logic [63:0] x;
    logic [63:0] hold;
    logic        op;

    total = 0;
    bad   = 0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    vt[0] = '{1'b0, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vt[1] = '{1'b0, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0};
    vt[2] = '{1'b0, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
    vt[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0000_0000_0000_0005, 1'b0};
    vt[4] = '{1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1234, 1'b0};
    vt[5] = '{1'b0, MIN64,                   MIN64,                   1'b1};
    vt[6] = '{1'b0, 64'h0000_0000_0000_0005, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0};
    vt[7] = '{1'b1, MIN64,                   MIN64,                   1'b1};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
`ifdef UPE_NEGSEQ_OVF_EN
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      check_op($sformatf("vec%0d", i), vt[i].op, vt[i].din, vt[i].exp, vt[i].ovf);

    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom);
      case ($urandom_range(0, 7))
        0: x = MIN64;
        1: x = 64'd0;
        2: x = '1;
        3: x = 64'($urandom_range(0, 3)) << (16 * $urandom_range(0, 3));
        default: x = {$urandom, $urandom};
      endcase
      check_op($sformatf("rand%0d", i), op, x, model_res(op, x), model_ovf(op, x));
    end

    // Backpressure: result held in DONE, a waiting operand is taken only after release.
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 1'b0;
    bus.in_data  = 64'd9;
    @(posedge clk);
    #1;
    bus.in_data = 64'h0000_0000_0000_0042;
    bus.in_op   = 1'b1;
    for (int c = 0; c < 20 && !bus.out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid", {63'd0, bus.out_valid}, 64'd1);
    hold = bus.out_data;
    chk("bp_data", hold, 64'hFFFF_FFFF_FFFF_FFF7);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_hold_data", bus.out_data, 64'hFFFF_FFFF_FFFF_FFF7);
      chk("bp_hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_release_busy", {63'd0, bus.busy}, 64'd0);
    chk("bp_release_valid", {63'd0, bus.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    chk("bp_reaccept_busy", {63'd0, bus.busy}, 64'd1);
    chk("bp_reaccept_in_ready", {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && !bus.out_valid; c++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_second_data", bus.out_data, 64'h0000_0000_0000_0042);
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle aborts with reset values.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 1'b0;
    bus.in_data  = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_out_data", bus.out_data, 64'd0);
    chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset", 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
